// File: rtl/qar_timer_wdt.sv
// qar_timer_wdt: memory-mapped prescaled timer and kickable watchdog on the qar_core data bus.
// Every decoded access gets a one-cycle registered response; irq_timer is a level output of the pending flags.
module qar_timer_wdt #(
    parameter logic [31:0] BASE_ADDR = 32'h4000_0000,
    parameter int          CNT_WIDTH = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_valid,
    input  logic        mem_we,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    output logic        mem_ready,
    output logic [31:0] mem_rdata,
    output logic        irq_timer,
    input  logic        irq_timer_ack,
    output logic        wdt_bite
);

    localparam logic [2:0] OFF_CTRL     = 3'd0;
    localparam logic [2:0] OFF_TMR_LOAD = 3'd1;
    localparam logic [2:0] OFF_TMR_CNT  = 3'd2;
    localparam logic [2:0] OFF_STATUS   = 3'd3;
    localparam logic [2:0] OFF_WDT_LOAD = 3'd4;
    localparam logic [2:0] OFF_WDT_KICK = 3'd5;
    localparam logic [2:0] OFF_PRESCALE = 3'd6;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    typedef enum logic {S_IDLE = 1'b0, S_RESP = 1'b1} state_t;

    state_t                 r_state, w_state_nxt;
    logic [31:0]            r_rdata;
    logic                   r_tmr_en, r_tmr_irq_en, r_auto_reload, r_wdt_en, r_wdt_irq_en;
    logic                   r_wdt_en_d;
    logic [CNT_WIDTH-1:0]   r_tmr_load, r_tmr_count, r_wdt_load, r_wdt_count;
    logic                   r_tmr_expired, r_wdt_expired, r_tmr_pend, r_wdt_pend;
    logic [15:0]            r_prescale, r_pre_cnt;

    logic        w_hit, w_accept, w_wr, w_w1c, w_w1c_tmr, w_w1c_wdt;
    logic [2:0]  w_off;
    logic [31:0] w_rd_data;
    logic        w_pre_run, w_tick;
    logic        w_wr_tcnt, w_tmr_step, w_tmr_fire;
    logic        w_kick, w_wdt_rise, w_wdt_reload, w_wdt_step, w_wdt_fire;
    logic        w_unused;

    assign w_hit     = mem_valid && (mem_addr[31:5] == BASE_ADDR[31:5]);
    assign w_accept  = (r_state == S_IDLE) && w_hit;
    assign w_off     = mem_addr[4:2];
    assign w_wr      = w_accept && mem_we;
    assign w_w1c     = w_wr && (w_off == OFF_STATUS);
    assign w_w1c_tmr = w_w1c && mem_wdata[0];
    assign w_w1c_wdt = w_w1c && mem_wdata[2];
    assign w_unused  = ^mem_addr[1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_rdata <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept)
                r_rdata <= mem_we ? '0 : w_rd_data;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        mem_ready   = 1'b0;
        mem_rdata   = '0;
        case (r_state)
            S_IDLE: if (w_hit) w_state_nxt = S_RESP;
            S_RESP: begin
                mem_ready   = 1'b1;
                mem_rdata   = r_rdata;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_rd_data = '0;
        case (w_off)
            OFF_CTRL:     w_rd_data = {26'd0, r_wdt_irq_en, r_wdt_en, 1'b0,
                                       r_auto_reload, r_tmr_irq_en, r_tmr_en};
            OFF_TMR_LOAD: w_rd_data = 32'(r_tmr_load);
            OFF_TMR_CNT:  w_rd_data = 32'(r_tmr_count);
            OFF_STATUS:   w_rd_data = {29'd0, r_wdt_expired, 1'b0, r_tmr_expired};
            OFF_WDT_LOAD: w_rd_data = 32'(r_wdt_load);
            OFF_PRESCALE: w_rd_data = {16'd0, r_prescale};
            default:      w_rd_data = '0;
        endcase
    end

    // >= keeps the tick period sane if PRESCALE is lowered below the running count
    assign w_pre_run = r_tmr_en | r_wdt_en;
    assign w_tick    = w_pre_run && (r_pre_cnt >= r_prescale);

    assign w_wr_tcnt  = w_wr && (w_off == OFF_TMR_CNT);
    assign w_tmr_step = w_tick && r_tmr_en && !w_wr_tcnt;
    assign w_tmr_fire = w_tmr_step && (r_tmr_count == CNT_ONE);

    assign w_kick       = w_wr && (w_off == OFF_WDT_KICK) && (mem_wdata == 32'h0000_005A);
    assign w_wdt_rise   = r_wdt_en && !r_wdt_en_d;
    assign w_wdt_reload = w_kick || w_wdt_rise;
    assign w_wdt_step   = w_tick && r_wdt_en && !w_wdt_reload && (r_wdt_count != '0);
    assign w_wdt_fire   = w_wdt_step && (r_wdt_count == CNT_ONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tmr_en      <= 1'b0;
            r_tmr_irq_en  <= 1'b0;
            r_auto_reload <= 1'b0;
            r_wdt_en      <= 1'b0;
            r_wdt_irq_en  <= 1'b0;
            r_wdt_en_d    <= 1'b0;
            r_tmr_load    <= '0;
            r_wdt_load    <= '0;
            r_prescale    <= '0;
            r_pre_cnt     <= '0;
        end else begin
            r_wdt_en_d <= r_wdt_en;
            if (w_wr && (w_off == OFF_CTRL)) begin
                r_tmr_en      <= mem_wdata[0];
                r_tmr_irq_en  <= mem_wdata[1];
                r_auto_reload <= mem_wdata[2];
                r_wdt_en      <= mem_wdata[4];
                r_wdt_irq_en  <= mem_wdata[5];
            end
            if (w_wr && (w_off == OFF_TMR_LOAD)) r_tmr_load <= CNT_WIDTH'(mem_wdata);
            if (w_wr && (w_off == OFF_WDT_LOAD)) r_wdt_load <= CNT_WIDTH'(mem_wdata);
            if (w_wr && (w_off == OFF_PRESCALE)) r_prescale <= mem_wdata[15:0];
            if (!w_pre_run || w_tick)
                r_pre_cnt <= '0;
            else
                r_pre_cnt <= r_pre_cnt + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tmr_count <= '0;
            r_wdt_count <= '0;
        end else begin
            if (w_wr_tcnt)
                r_tmr_count <= CNT_WIDTH'(mem_wdata);
            else if (w_tmr_fire)
                r_tmr_count <= r_auto_reload ? r_tmr_load : '0;
            else if (w_tmr_step && (r_tmr_count != '0))
                r_tmr_count <= r_tmr_count - CNT_ONE;

            if (w_wdt_reload)
                r_wdt_count <= r_wdt_load;
            else if (w_wdt_step)
                r_wdt_count <= r_wdt_count - CNT_ONE;
        end
    end

    // A new expiry outranks a simultaneous W1C or acknowledge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tmr_expired <= 1'b0;
            r_wdt_expired <= 1'b0;
            r_tmr_pend    <= 1'b0;
            r_wdt_pend    <= 1'b0;
        end else begin
            r_tmr_expired <= w_tmr_fire || (r_tmr_expired && !w_w1c_tmr);
            r_wdt_expired <= w_wdt_fire || (r_wdt_expired && !w_w1c_wdt);
            r_tmr_pend    <= (w_tmr_fire && r_tmr_irq_en) ||
                             (r_tmr_pend && !irq_timer_ack && !w_w1c_tmr);
            r_wdt_pend    <= (w_wdt_fire && r_wdt_irq_en) ||
                             (r_wdt_pend && !irq_timer_ack && !w_w1c_wdt);
        end
    end

    assign irq_timer = r_tmr_pend | r_wdt_pend;
    assign wdt_bite  = r_wdt_expired & r_wdt_en;

endmodule
